slave_split_gen: RTL and testbench

//  Parametrised memory-backed bus slave with optional SPLIT support; successor to the fixed 3rd-slave split design.

---
 rtl/bus_pkg.sv | 21 ++
 rtl/slave_mem.sv | 28 ++
 rtl/slave_split_gen.sv | 147 ++++++++++++++
 tb/tb_slave_split_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and helpers for the split-capable bus slave.
// Holds the FSM state encoding, transfer-direction constants and the split-counter sizing rule.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RESPOND,
        SPLIT_WAIT,
        RESUME_REQ
    } slave_state_t;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Width needed to hold 0..latency, never narrower than one bit.
    function automatic int cnt_width(input int latency);
        return (latency > 0) ? $clog2(latency + 1) : 1;
    endfunction

endpackage

// File: rtl/slave_mem.sv
// Single-port synchronous RAM backing the bus slave.
// Write on we; the read port is registered and returns the old word on a same-address write.
module slave_mem #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_reg[addr] <= wdata;
        end
        rdata_reg <= mem_reg[addr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/slave_split_gen.sv
// Memory-backed bus slave: fast-region accesses complete in place, split-region accesses
// release the bus, wait SPLIT_LATENCY cycles, re-request it and then complete.
module slave_split_gen
    import bus_pkg::*;
#(
    parameter int          ADDR_WIDTH    = 12,
    parameter int          DATA_WIDTH    = 8,
    parameter int          SPLIT_LATENCY = 8,
    parameter int unsigned SPLIT_BASE    = 'h800
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sl,
    input  logic                  valid,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  split,
    output logic                  arbiter_req,
    input  logic                  arbiter_grant
);

    localparam int               CNT_W    = cnt_width(SPLIT_LATENCY);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((SPLIT_LATENCY > 0) ? SPLIT_LATENCY - 1 : 0);
    localparam bit               SPLIT_EN = (SPLIT_LATENCY > 0);

    slave_state_t          state_reg, state_next;
    logic                  mode_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;
    logic                  split_path_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic                  req_prev_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  ready_reg;
    logic                  split_reg;
    logic                  arb_req_reg;

    logic                  req_now;
    logic                  accept;
    logic                  go_split;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign req_now  = sl && valid;
    // Only a fresh request is taken, so a master still holding valid after ready is not served twice.
    assign accept   = req_now && !req_prev_reg;
    assign go_split = SPLIT_EN && (32'(addr) >= SPLIT_BASE);

    slave_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_next = state_reg;
        mem_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = go_split ? SPLIT_WAIT : ACCESS;
                end
            end
            ACCESS: begin
                // A fast-path master may withdraw; a resumed split owns the bus and cannot abort.
                if (!split_path_reg && !req_now) begin
                    state_next = IDLE;
                end else begin
                    mem_we     = (mode_reg == MODE_WRITE);
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            SPLIT_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESUME_REQ;
                end
            end
            RESUME_REQ: begin
                if (arbiter_grant) begin
                    state_next = ACCESS;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            mode_reg       <= MODE_READ;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            split_path_reg <= 1'b0;
            cnt_reg        <= '0;
            req_prev_reg   <= 1'b0;
            rdata_reg      <= '0;
            ready_reg      <= 1'b0;
            split_reg      <= 1'b0;
            arb_req_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            req_prev_reg <= req_now;
            ready_reg    <= (state_reg == RESPOND);
            rdata_reg    <= (state_reg == RESPOND && mode_reg == MODE_READ) ? mem_rdata : '0;

            if (state_reg == IDLE && accept) begin
                mode_reg       <= mode;
                addr_reg       <= addr;
                wdata_reg      <= wdata;
                split_path_reg <= go_split;
                split_reg      <= go_split;
                cnt_reg        <= CNT_LOAD;
            end else if (state_reg == SPLIT_WAIT && cnt_reg != '0) begin
                cnt_reg <= cnt_reg - 1'b1;
            end

            if (state_reg == SPLIT_WAIT && cnt_reg == '0) begin
                arb_req_reg <= 1'b1;
            end

            // Bus ownership indicators drop on the same edge the completion pulse rises.
            if (state_reg == RESPOND) begin
                split_reg   <= 1'b0;
                arb_req_reg <= 1'b0;
            end
        end
    end

    assign rdata       = rdata_reg;
    assign ready       = ready_reg;
    assign split       = split_reg;
    assign arbiter_req = arb_req_reg;

endmodule

// File: tb/tb_slave_split_gen.sv
// Randomized scoreboard bench for slave_split_gen: stimulus tasks push expected completions,
// a negedge monitor pops and checks them against an associative-array memory model.
module tb_slave_split_gen;

    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int LAT = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          sl, valid, mode, arbiter_grant;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, rdata;
    logic          ready, split, arbiter_req;

    logic          sl0, valid0, mode0, arbiter_grant0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0, rdata0;
    logic          ready0, split0, arbiter_req0;

    always #5 clk = ~clk;

    slave_split_gen #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .SPLIT_LATENCY (LAT), .SPLIT_BASE ('h800)
    ) dut (
        .clk (clk), .rst_n (rst_n), .sl (sl), .valid (valid), .mode (mode),
        .addr (addr), .wdata (wdata), .rdata (rdata), .ready (ready), .split (split),
        .arbiter_req (arbiter_req), .arbiter_grant (arbiter_grant)
    );

    slave_split_gen #(
        .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .SPLIT_LATENCY (0), .SPLIT_BASE ('h800)
    ) dut0 (
        .clk (clk), .rst_n (rst_n), .sl (sl0), .valid (valid0), .mode (mode0),
        .addr (addr0), .wdata (wdata0), .rdata (rdata0), .ready (ready0), .split (split0),
        .arbiter_req (arbiter_req0), .arbiter_grant (arbiter_grant0)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            edge_n;
        logic          mode;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] model [int];
    int            checks = 0;
    int            errors = 0;
    int            edge_cnt = 0;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_ready", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("rdata", rdata, mon_e.data);
                check("ready_edge", edge_cnt, mon_e.edge_n);
                check("split_at_ready", split, 0);
                check("req_at_ready", arbiter_req, 0);
                $display("txn %s addr=%03h rdata=%02h edge=%0d", mon_e.mode ? "WR" : "RD",
                         mon_e.addr, rdata, edge_cnt);
            end
        end else begin
            check("rdata_idle", rdata, 0);
        end
    end

    task automatic wait_sb();
        for (int i = 0; i < 12 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check("ready_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic push_exp(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input int edge_n);
        exp_t e;
        e.data   = m ? '0 : model[int'(a)];
        e.edge_n = edge_n;
        e.mode   = m;
        e.addr   = a;
        sb.push_back(e);
        if (m) model[int'(a)] = d;
    endtask

    task automatic fast_txn(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input bit abort);
        int acc;
        @(negedge clk);
        sl = 1; valid = 1; mode = m; addr = a; wdata = d;
        acc = edge_cnt + 1;
        if (abort) begin
            @(negedge clk);
            check("split_fast", split, 0);
            if ($urandom_range(0, 1) == 1) sl = 0; else valid = 0;
            repeat (3) @(negedge clk);
            $display("txn AB addr=%03h aborted edge=%0d", a, edge_cnt);
        end else begin
            push_exp(m, a, d, acc + 2);
            @(negedge clk);
            check("split_fast", split, 0);
            check("req_fast", arbiter_req, 0);
            wait_sb();
        end
        sl = 0; valid = 0;
    endtask

    task automatic split_txn(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int delay, input bit pre, input bit rst_mid);
        int acc, g;
        @(negedge clk);
        sl = 1; valid = 1; mode = m; addr = a; wdata = d; arbiter_grant = 0;
        acc = edge_cnt + 1;
        @(negedge clk);
        check("split_after_accept", split, 1);
        check("req_early", arbiter_req, 0);
        sl = 0; valid = 0; mode = ~m; addr = a ^ 12'h0F0; wdata = ~d;
        if (pre) arbiter_grant = 1;
        if (rst_mid) begin
            repeat (3) @(negedge clk);
            rst_n = 0;
            @(negedge clk);
            rst_n = 1;
            check("rst_ready", ready, 0);
            check("rst_split", split, 0);
            check("rst_req", arbiter_req, 0);
            check("rst_rdata", rdata, 0);
            arbiter_grant = 0;
            repeat (LAT + 4) @(negedge clk);
            $display("txn RS addr=%03h discarded edge=%0d", a, edge_cnt);
            return;
        end
        for (int i = 0; i < LAT + 4 && arbiter_req !== 1'b1; i++) @(negedge clk);
        check("req_rise_edge", edge_cnt, acc + LAT);
        check("split_in_resume", split, 1);
        if (pre) begin
            g = edge_cnt + 1;
        end else begin
            repeat (delay) @(negedge clk);
            check("req_held", arbiter_req, 1);
            arbiter_grant = 1;
            g = edge_cnt + 1;
        end
        push_exp(m, a, d, g + 2);
        @(negedge clk);
        arbiter_grant = 1'($urandom_range(0, 1));
        wait_sb();
        arbiter_grant = 0;
    endtask

    task automatic nosplit_txn(input logic m, input logic [AW-1:0] a, input logic [DW-1:0] d,
                               input logic [DW-1:0] exp_d);
        int acc;
        bit seen_split;
        seen_split = 0;
        @(negedge clk);
        sl0 = 1; valid0 = 1; mode0 = m; addr0 = a; wdata0 = d;
        acc = edge_cnt + 1;
        for (int i = 0; i < 6 && ready0 !== 1'b1; i++) begin
            @(negedge clk);
            if (split0 === 1'b1) seen_split = 1;
        end
        check("nosplit_ready_edge", edge_cnt, acc + 2);
        check("nosplit_rdata", rdata0, exp_d);
        check("nosplit_split", 32'(seen_split), 0);
        check("nosplit_req", arbiter_req0, 0);
        $display("txn L0 %s addr=%03h rdata=%02h edge=%0d", m ? "WR" : "RD", a, rdata0, edge_cnt);
        sl0 = 0; valid0 = 0;
        @(negedge clk);
    endtask

    logic [AW-1:0] pool [8];

    initial begin
        pool = '{12'h000, 12'h005, 12'h7FF, 12'h123, 12'h800, 12'h801, 12'hFFF, 12'hABC};
        rst_n = 0; sl = 0; valid = 0; mode = 0; addr = '0; wdata = '0; arbiter_grant = 1;
        sl0 = 0; valid0 = 0; mode0 = 0; addr0 = '0; wdata0 = '0; arbiter_grant0 = 1;
        repeat (2) @(negedge clk);
        check("reset_ready", ready, 0);
        check("reset_split", split, 0);
        check("reset_req", arbiter_req, 0);
        check("reset_rdata", rdata, 0);
        rst_n = 1;

        // Fast path with a stray grant held high.
        fast_txn(1, 12'h001, 8'hA5, 0);
        fast_txn(0, 12'h001, 8'h00, 0);
        fast_txn(1, 12'h002, 8'h4B, 0);
        fast_txn(0, 12'h002, 8'h00, 0);
        arbiter_grant = 0;

        // Aborted fast write must leave the old word.
        fast_txn(1, 12'h003, 8'h21, 0);
        fast_txn(1, 12'h003, 8'hEE, 1);
        fast_txn(0, 12'h003, 8'h00, 0);

        // Split write with long grant delay, then read back.
        split_txn(1, 12'h900, 8'h3C, 12, 0, 0);
        split_txn(0, 12'h900, 8'h00, 3, 0, 0);

        // Reset during SPLIT_WAIT discards the write; pre-asserted grant on the read.
        split_txn(1, 12'h901, 8'h11, 2, 0, 0);
        split_txn(1, 12'h901, 8'h77, 0, 0, 1);
        split_txn(0, 12'h901, 8'h00, 0, 1, 0);

        // Split disabled: split-region address behaves as fast.
        nosplit_txn(1, 12'h900, 8'h5A, 8'h00);
        nosplit_txn(0, 12'h900, 8'h00, 8'h5A);

        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] a;
            logic          m;
            logic [DW-1:0] d;
            a = pool[$urandom_range(0, 7)];
            d = 8'($urandom);
            m = !model.exists(int'(a)) || ($urandom_range(0, 1) == 1);
            if (a < 12'h800) begin
                arbiter_grant = 1'($urandom_range(0, 1));
                fast_txn(m, a, d, $urandom_range(0, 5) == 0);
                arbiter_grant = 0;
            end else begin
                split_txn(m, a, d, $urandom_range(0, 4), $urandom_range(0, 3) == 0, 0);
            end
        end

        repeat (5) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
